// File: rtl/store_buffer.sv
// Posted-store FIFO in front of a single-port data memory: stores retire in idle
// cycles, loads forward from the youngest matching buffered store.
module store_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 18,
  parameter  int DATA_W = 32,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_wr_en,
  output logic [DATA_W-1:0] dm_wr_data,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;

  logic              w_full, w_busy, w_drain, w_enq, w_hit;
  logic [PW-1:0]     w_idx;
  logic [DATA_W-1:0] w_fwd;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_busy = (r_count != '0);

  // Qualified by rst so a reset cycle never writes memory: pending stores are dropped.
  assign stall   = rst && ((mem_w_en && w_full) || (flush && w_busy));
  assign w_drain = rst && w_busy && (stall || (!mem_r_en && !mem_w_en));
  assign w_enq   = rst && mem_w_en && !stall;

  // Walk oldest to youngest from head so the last hit wins, independent of wrap.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx][ADDR_W-1:2] == addr[ADDR_W-1:2])) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
  end

  assign rd_data    = w_hit ? w_fwd : dm_rd_data;
  assign dm_addr    = w_drain ? r_addr[r_head] : addr;
  assign dm_wr_en   = w_drain;
  assign dm_wr_data = r_data[r_head];
  assign empty      = !w_busy;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= addr;
        r_data[r_tail] <= wr_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_drain) r_head <= r_head + PW'(1);
      if (w_enq)        r_count <= r_count + CW'(1);
      else if (w_drain) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural word memory on the dm port.
module tb_store_buffer;
  logic        clk = 0;
  logic        rst, mem_r_en, mem_w_en, flush;
  logic [17:0] addr, dm_addr;
  logic [31:0] wr_data, rd_data, dm_wr_data, dm_rd_data;
  logic        stall, dm_wr_en, empty;
  logic [2:0]  count;

  int n_chk = 0, n_fail = 0, n_wr = 0, wr_mark;
  logic [31:0] mem [0:65535];

  store_buffer dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wr_data(wr_data), .flush(flush), .rd_data(rd_data),
    .stall(stall), .dm_addr(dm_addr), .dm_wr_en(dm_wr_en),
    .dm_wr_data(dm_wr_data), .dm_rd_data(dm_rd_data), .empty(empty),
    .count(count)
  );

  always #5 clk = ~clk;

  assign dm_rd_data = mem[dm_addr[17:2]];
  always @(posedge clk)
    if (dm_wr_en) begin
      mem[dm_addr[17:2]] <= dm_wr_data;
      n_wr <= n_wr + 1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [17:0] a,
                     input logic [31:0] d, input logic f);
    mem_r_en = r; mem_w_en = w; addr = a; wr_data = d; flush = f;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 18'h0, 32'h0, 0);
  endtask

  task automatic store(input logic [17:0] a, input logic [31:0] d);
    drv(0, 1, a, d, 0);
    cyc();
  endtask

  task automatic chk_drain(input string tag, input logic [17:0] a, input logic [31:0] d);
    chk({tag, "_we"},   32'(dm_wr_en), 32'h1);
    chk({tag, "_addr"}, 32'(dm_addr),  32'(a));
    chk({tag, "_data"}, dm_wr_data,    d);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    rst = 0; idle();
    cyc(); cyc();
    // Random activity, then reset held two cycles
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 255) << 2), $urandom, 0);
      cyc();
    end
    drv(0, 1, 18'h40, 32'h5, 0);
    cyc();
    rst = 0; idle(); cyc(); cyc();
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_we",    32'(dm_wr_en), 32'h0);
    rst = 1; idle(); cyc();

    // Single store, forwarded load, then idle retirement
    drv(0, 1, 18'h400, 32'hDEADBEEF, 0);
    chk("st1_stall", 32'(stall), 32'h0);
    chk("st1_we", 32'(dm_wr_en), 32'h0);
    cyc();
    drv(1, 0, 18'h400, 32'h0, 0);
    chk("fwd1_data", rd_data, 32'hDEADBEEF);
    chk("fwd1_we", 32'(dm_wr_en), 32'h0);
    chk("fwd1_count", 32'(count), 32'h1);
    cyc();
    idle();
    chk_drain("ret1", 18'h400, 32'hDEADBEEF);
    cyc();
    chk("ret1_count", 32'(count), 32'h0);
    chk("ret1_mem", mem[18'h400 >> 2], 32'hDEADBEEF);

    // Fill to DEPTH (entries wrap past index 3), then store into a full buffer
    store(18'h400, 32'hA0); store(18'h404, 32'hA1);
    store(18'h408, 32'hA2); store(18'h40C, 32'hA3);
    chk("fill_count", 32'(count), 32'h4);
    drv(0, 1, 18'h410, 32'hA4, 0);
    chk("full_stall", 32'(stall), 32'h1);
    chk_drain("full_ret", 18'h400, 32'hA0);
    cyc();
    chk("held_stall", 32'(stall), 32'h0);
    chk("held_count", 32'(count), 32'h3);
    cyc();
    chk("held_acc_count", 32'(count), 32'h4);
    drv(1, 0, 18'h40C, 32'h0, 0);
    chk("wrap_fwd", rd_data, 32'hA3);
    drv(1, 0, 18'h410, 32'h0, 0);
    chk("wrap_fwd_new", rd_data, 32'hA4);
    chk("wrap_fwd_we", 32'(dm_wr_en), 32'h0);
    idle();
    chk_drain("wrap_d0", 18'h404, 32'hA1); cyc();
    chk_drain("wrap_d1", 18'h408, 32'hA2); cyc();
    chk_drain("wrap_d2", 18'h40C, 32'hA3); cyc();
    chk_drain("wrap_d3", 18'h410, 32'hA4); cyc();
    chk("wrap_empty", 32'(empty), 32'h1);

    // Same-word stores straddling the wrap point: youngest wins, both retire
    store(18'h600, 32'h9); store(18'h500, 32'h1); store(18'h500, 32'h2);
    drv(1, 0, 18'h502, 32'h0, 0);
    chk("same_fwd", rd_data, 32'h2);
    idle();
    chk_drain("same_d0", 18'h600, 32'h9); cyc();
    chk_drain("same_d1", 18'h500, 32'h1); cyc();
    chk_drain("same_d2", 18'h500, 32'h2); cyc();
    chk("same_mem", mem[18'h500 >> 2], 32'h2);

    // Flush with three entries, then with an empty buffer
    store(18'h700, 32'h7); store(18'h704, 32'h8); store(18'h708, 32'h9);
    drv(0, 0, 18'h0, 32'h0, 1);
    chk("fl_stall0", 32'(stall), 32'h1); chk_drain("fl_d0", 18'h700, 32'h7); cyc();
    chk("fl_stall1", 32'(stall), 32'h1); chk_drain("fl_d1", 18'h704, 32'h8); cyc();
    chk("fl_stall2", 32'(stall), 32'h1); chk_drain("fl_d2", 18'h708, 32'h9); cyc();
    chk("fl_done_stall", 32'(stall), 32'h0);
    chk("fl_done_count", 32'(count), 32'h0);
    cyc();
    chk("fl_empty_stall", 32'(stall), 32'h0);

    // Reset discards pending stores; loads see old memory contents
    idle();
    mem[18'h800 >> 2] = 32'h11111111;
    mem[18'h804 >> 2] = 32'h22222222;
    store(18'h800, 32'hBAD0); store(18'h804, 32'hBAD1);
    wr_mark = n_wr;
    rst = 0; idle();
    chk("rstp_we", 32'(dm_wr_en), 32'h0);
    cyc();
    rst = 1; idle();
    chk("rstp_we_after", 32'(dm_wr_en), 32'h0);
    chk("rstp_count", 32'(count), 32'h0);
    drv(1, 0, 18'h800, 32'h0, 0);
    chk("rstp_ld0", rd_data, 32'h11111111);
    drv(1, 0, 18'h804, 32'h0, 0);
    chk("rstp_ld1", rd_data, 32'h22222222);
    cyc(); idle(); cyc();
    chk("rstp_nwr", 32'(n_wr), 32'(wr_mark));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
